// File: rtl/eth_recv.sv
// Receive-side Ethernet/IPv4/UDP header parser and filter for the 64-bit 10G MAC stream.
// Captures source fields and a payload sequence number, strobes on accepted frames, counts drops.
module eth_recv #(
    parameter logic [47:0] eth_addr  = 48'h90_E2_BA_5D_8D_C8,
    parameter logic [15:0] eth_proto = 16'h0800,
    parameter logic [31:0] ip_daddr  = {8'd192, 8'd168, 8'd1, 8'd122},
    parameter logic [15:0] udp_dport = 16'd3776
) (
    input  logic        clk156,
    input  logic        reset,
    input  logic        m_axis_rx_tvalid,
    input  logic [63:0] m_axis_rx_tdata,
    input  logic [7:0]  m_axis_rx_tkeep,
    input  logic        m_axis_rx_tlast,
    input  logic        m_axis_rx_tuser,
    output logic        pkt_valid,
    output logic [47:0] pkt_eth_src,
    output logic [31:0] pkt_ip_saddr,
    output logic [15:0] pkt_udp_sport,
    output logic [15:0] pkt_udp_len,
    output logic [31:0] pkt_seq,
    output logic [31:0] rx_pkt_cnt,
    output logic [31:0] rx_drop_cnt,
    output logic [31:0] rx_csum_err_cnt
);

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;

    state_t      state_q, state_d;
    logic [2:0]  beat_cnt_q, beat_cnt_d;
    logic [23:0] sum_q, sum_d;
    logic        hdr_bad_q, hdr_bad_d;
    logic        b5_ok_q, b5_ok_d;
    logic [47:0] src_q, src_d;
    logic [31:0] saddr_q, saddr_d;
    logic [15:0] sport_q, sport_d;
    logic [15:0] ulen_q, ulen_d;
    logic [31:0] seq_q, seq_d;

    logic        pkt_valid_q, pkt_valid_d;
    logic [47:0] pkt_eth_src_q, pkt_eth_src_d;
    logic [31:0] pkt_ip_saddr_q, pkt_ip_saddr_d;
    logic [15:0] pkt_udp_sport_q, pkt_udp_sport_d;
    logic [15:0] pkt_udp_len_q, pkt_udp_len_d;
    logic [31:0] pkt_seq_q, pkt_seq_d;
    logic [31:0] rx_pkt_cnt_q, rx_pkt_cnt_d;
    logic [31:0] rx_drop_cnt_q, rx_drop_cnt_d;
    logic [31:0] rx_csum_err_cnt_q, rx_csum_err_cnt_d;

    logic [16:0] fold1;
    logic [15:0] fold2;
    logic        csum_ok;
    logic        accept;

    // Lane k carries wire byte 8n+k; words are big-endian pairs of adjacent lanes.
    logic [7:0]  rx_byte [8];
    logic [15:0] rx_word [4];
    logic [23:0] sum4;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_byte
            assign rx_byte[gi] = m_axis_rx_tdata[8*gi +: 8];
        end
        for (genvar gi = 0; gi < 4; gi++) begin : g_word
            assign rx_word[gi] = {rx_byte[2*gi], rx_byte[2*gi+1]};
        end
    endgenerate

    assign sum4 = 24'(rx_word[0]) + 24'(rx_word[1]) + 24'(rx_word[2]) + 24'(rx_word[3]);

    always_comb begin
        state_d           = state_q;
        beat_cnt_d        = beat_cnt_q;
        sum_d             = sum_q;
        hdr_bad_d         = hdr_bad_q;
        b5_ok_d           = b5_ok_q;
        src_d             = src_q;
        saddr_d           = saddr_q;
        sport_d           = sport_q;
        ulen_d            = ulen_q;
        seq_d             = seq_q;
        pkt_valid_d       = 1'b0;
        pkt_eth_src_d     = pkt_eth_src_q;
        pkt_ip_saddr_d    = pkt_ip_saddr_q;
        pkt_udp_sport_d   = pkt_udp_sport_q;
        pkt_udp_len_d     = pkt_udp_len_q;
        pkt_seq_d         = pkt_seq_q;
        rx_pkt_cnt_d      = rx_pkt_cnt_q;
        rx_drop_cnt_d     = rx_drop_cnt_q;
        rx_csum_err_cnt_d = rx_csum_err_cnt_q;
        fold1             = 17'd0;
        fold2             = 16'd0;
        csum_ok           = 1'b0;
        accept            = 1'b0;

        if (m_axis_rx_tvalid) begin
            case (beat_cnt_q)
                3'd0: begin
                    if ({rx_byte[0], rx_byte[1], rx_byte[2], rx_byte[3], rx_byte[4], rx_byte[5]} != eth_addr &&
                        {rx_byte[0], rx_byte[1], rx_byte[2], rx_byte[3], rx_byte[4], rx_byte[5]} != 48'hFFFF_FFFF_FFFF)
                        hdr_bad_d = 1'b1;
                    src_d[47:32] = rx_word[3];
                end
                3'd1: begin
                    src_d[31:0] = {rx_word[0], rx_word[1]};
                    if (rx_word[2] != eth_proto || rx_byte[6] != 8'h45)
                        hdr_bad_d = 1'b1;
                    sum_d = sum_q + 24'(rx_word[3]);
                end
                3'd2: begin
                    if ((rx_word[2] & 16'h3FFF) != 16'h0000 || rx_byte[7] != 8'd17)
                        hdr_bad_d = 1'b1;
                    sum_d = sum_q + sum4;
                end
                3'd3: begin
                    saddr_d = {rx_byte[2], rx_byte[3], rx_byte[4], rx_byte[5]};
                    if (rx_word[3] != ip_daddr[31:16])
                        hdr_bad_d = 1'b1;
                    sum_d = sum_q + sum4;
                end
                3'd4: begin
                    if (rx_word[0] != ip_daddr[15:0] || rx_word[2] != udp_dport)
                        hdr_bad_d = 1'b1;
                    sport_d = rx_word[1];
                    ulen_d  = rx_word[3];
                    sum_d   = sum_q + 24'(rx_word[0]);
                end
                3'd5: begin
                    seq_d   = {rx_byte[2], rx_byte[3], rx_byte[4], rx_byte[5]};
                    b5_ok_d = m_axis_rx_tkeep[5];
                end
                default: ;
            endcase

            if (m_axis_rx_tlast) begin
                // Two folds suffice: ten words never exceed 20 bits.
                fold1   = {1'b0, sum_d[15:0]} + {9'd0, sum_d[23:16]};
                fold2   = fold1[15:0] + {15'd0, fold1[16]};
                csum_ok = (fold2 == 16'hFFFF);
                accept  = !m_axis_rx_tuser && !hdr_bad_d && b5_ok_d && csum_ok;
                if (accept) begin
                    pkt_valid_d     = 1'b1;
                    pkt_eth_src_d   = src_d;
                    pkt_ip_saddr_d  = saddr_d;
                    pkt_udp_sport_d = sport_d;
                    pkt_udp_len_d   = ulen_d;
                    pkt_seq_d       = seq_d;
                    rx_pkt_cnt_d    = rx_pkt_cnt_q + 32'd1;
                end else begin
                    rx_drop_cnt_d = rx_drop_cnt_q + 32'd1;
                    if (!csum_ok && beat_cnt_q >= 3'd4)
                        rx_csum_err_cnt_d = rx_csum_err_cnt_q + 32'd1;
                end
                state_d    = IDLE;
                beat_cnt_d = 3'd0;
                sum_d      = 24'd0;
                hdr_bad_d  = 1'b0;
                b5_ok_d    = 1'b0;
            end else begin
                if (beat_cnt_q != 3'd7)
                    beat_cnt_d = beat_cnt_q + 3'd1;
                case (state_q)
                    IDLE:    state_d = HDR;
                    HDR:     if (beat_cnt_q == 3'd5) state_d = PAYLOAD;
                    default: state_d = state_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk156) begin
        if (reset) begin
            state_q           <= IDLE;
            beat_cnt_q        <= 3'd0;
            sum_q             <= 24'd0;
            hdr_bad_q         <= 1'b0;
            b5_ok_q           <= 1'b0;
            src_q             <= 48'd0;
            saddr_q           <= 32'd0;
            sport_q           <= 16'd0;
            ulen_q            <= 16'd0;
            seq_q             <= 32'd0;
            pkt_valid_q       <= 1'b0;
            pkt_eth_src_q     <= 48'd0;
            pkt_ip_saddr_q    <= 32'd0;
            pkt_udp_sport_q   <= 16'd0;
            pkt_udp_len_q     <= 16'd0;
            pkt_seq_q         <= 32'd0;
            rx_pkt_cnt_q      <= 32'd0;
            rx_drop_cnt_q     <= 32'd0;
            rx_csum_err_cnt_q <= 32'd0;
        end else begin
            state_q           <= state_d;
            beat_cnt_q        <= beat_cnt_d;
            sum_q             <= sum_d;
            hdr_bad_q         <= hdr_bad_d;
            b5_ok_q           <= b5_ok_d;
            src_q             <= src_d;
            saddr_q           <= saddr_d;
            sport_q           <= sport_d;
            ulen_q            <= ulen_d;
            seq_q             <= seq_d;
            pkt_valid_q       <= pkt_valid_d;
            pkt_eth_src_q     <= pkt_eth_src_d;
            pkt_ip_saddr_q    <= pkt_ip_saddr_d;
            pkt_udp_sport_q   <= pkt_udp_sport_d;
            pkt_udp_len_q     <= pkt_udp_len_d;
            pkt_seq_q         <= pkt_seq_d;
            rx_pkt_cnt_q      <= rx_pkt_cnt_d;
            rx_drop_cnt_q     <= rx_drop_cnt_d;
            rx_csum_err_cnt_q <= rx_csum_err_cnt_d;
        end
    end

    assign pkt_valid       = pkt_valid_q;
    assign pkt_eth_src     = pkt_eth_src_q;
    assign pkt_ip_saddr    = pkt_ip_saddr_q;
    assign pkt_udp_sport   = pkt_udp_sport_q;
    assign pkt_udp_len     = pkt_udp_len_q;
    assign pkt_seq         = pkt_seq_q;
    assign rx_pkt_cnt      = rx_pkt_cnt_q;
    assign rx_drop_cnt     = rx_drop_cnt_q;
    assign rx_csum_err_cnt = rx_csum_err_cnt_q;

endmodule

// File: doc/eth_recv.md
Name: eth_recv

Overview:
- Receive-side counterpart of the UDP frame generator, on the 156.25 MHz 64-bit AXI-Stream path from the 10G MAC.
- Parses Ethernet/IPv4/UDP headers on the fly and filters on destination MAC, IP address and UDP port.
- Verifies the IPv4 header checksum and extracts source fields plus a 32-bit big-endian sequence number from the first 4 payload bytes.
- Reports accepted frames with a one-cycle strobe and keeps wrap-around statistics counters.

Parameters:
- eth_addr, 48'h90_E2_BA_5D_8D_C8, local MAC; broadcast FF:FF:FF:FF:FF:FF is also accepted.
- eth_proto, ETH_P_IP, required EtherType.
- ip_daddr, {8'd192,8'd168,8'd1,8'd122}, required IPv4 destination.
- udp_dport, 16'd3776, required UDP destination port.

Ports:
- clk156  in  1  sole clock, 156.25 MHz.
- reset  in  1  synchronous, active-high.
- m_axis_rx_tvalid  in  1  beat valid; no backpressure, so there is no tready.
- m_axis_rx_tdata  in  64  frame byte 8n+k on tdata[8k+7:8k].
- m_axis_rx_tkeep  in  8  byte enables, contiguous from bit 0; all 1s except on the last beat.
- m_axis_rx_tlast  in  1  last beat of frame.
- m_axis_rx_tuser  in  1  MAC bad-frame flag, sampled on the tlast beat.
- pkt_valid  out  1  one-cycle strobe: frame accepted.
- pkt_eth_src  out  48  source MAC.
- pkt_ip_saddr  out  32  IPv4 source address.
- pkt_udp_sport  out  16  UDP source port.
- pkt_udp_len  out  16  UDP length field.
- pkt_seq  out  32  payload bytes 42..45, big-endian.
- rx_pkt_cnt  out  32  accepted frames.
- rx_drop_cnt  out  32  rejected frames, all causes.
- rx_csum_err_cnt  out  32  frames with a bad IP checksum.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, beat counter 0, checksum accumulator 0. The next valid beat after reset is treated as beat 0. Reset asserted mid-frame abandons that frame with no counter update.
- Advance only on cycles with tvalid=1. Idle cycles inside a frame are legal and change no state.
- Beat index counter is 3 bits and saturates at 7.
- FSM states and transitions:
  - IDLE: first valid beat is beat 0 → HDR. If that beat also has tlast → decide immediately (short frame).
  - HDR: beats 1..5, header fields captured into shadow registers. After beat 5 without tlast → PAYLOAD. tlast at any beat → decide.
  - PAYLOAD: discard beats until tlast → decide.
  - Decide: → IDLE the following cycle.
- Byte map:
  - dst 0-5, src 6-11, EtherType 12-13, ver/ihl 14, tot_len 16-17, frag_off 20-21, proto 23, check 24-25.
  - saddr 26-29, daddr 30-33, sport 34-35, dport 36-37, udp len 38-39, seq 42-45.
- Multi-byte fields are big-endian on the wire, so each field's byte order is reversed relative to tdata lane order.
- Checksum:
  - Ones-complement accumulate the ten 16-bit words at bytes 14..33 in a 24-bit register: beat1 1 word, beat2 4, beat3 4, beat4 1.
  - At decide, fold twice (sum[15:0]+sum[23:16], then again for the carry). The result must be 16'hFFFF.
- Accept only if all of:
  - tuser=0 on the tlast beat.
  - dst == eth_addr or broadcast.
  - EtherType == eth_proto.
  - byte14 == 8'h45.
  - proto == 17.
  - frag_off & 16'h3FFF == 0 (MF and offset clear).
  - daddr == ip_daddr.
  - dport == udp_dport.
  - checksum ok.
  - beat 5 reached with tkeep[5]=1, i.e. at least 46 bytes.
- Accept result:
  - pkt_valid=1 exactly one cycle after the tlast beat.
  - pkt_* registers load from the shadow registers in that same cycle and hold until the next accept.
  - rx_pkt_cnt increments.
- Reject result:
  - No pkt_valid.
  - rx_drop_cnt increments.
  - rx_csum_err_cnt also increments if the checksum failed and at least beat 4 was received.
- Counters wrap at 2^32 with no saturation.
- A new frame whose beat 0 arrives in the cycle after tlast is parsed normally; the decide outputs and the new beat 0 overlap without loss.

Test Plan:
- Generator-default 60 B frame (dst 90:E2:BA:5D:8D:C8, 192.168.1.111→.122, ports 3776, tot_len 46, check 16'hF685, zero payload) → pkt_valid one cycle after beat 7; pkt_ip_saddr=32'hC0A8016F, pkt_udp_sport=3776, pkt_udp_len=26, pkt_seq=0, rx_pkt_cnt=1.
- Same frame with check corrupted to 16'hF684 → no pkt_valid; rx_drop_cnt=1, rx_csum_err_cnt=1.
- Frames with dport=3777, dst=00:11:22:33:44:66, and tuser=1 respectively → each dropped; rx_drop_cnt=3, rx_csum_err_cnt=0; pkt_* unchanged from the last accept.
- Broadcast dst, payload seq bytes 00 00 01 02, tvalid deasserted for 3 cycles between beats 2 and 3 → accepted, pkt_seq=32'h00000102.
- Back-to-back frames (beat 0 of frame 2 in the cycle after tlast of frame 1), then a 24-byte frame with tlast on beat 2 → two pkt_valid pulses, short frame dropped; rx_pkt_cnt=2, rx_drop_cnt=1.
- Reset asserted on beat 3 of a good frame, then a good frame → no counter change for the first frame; second frame accepted, rx_pkt_cnt=1.
